// File: rtl/c_result_drain.sv
// c_result_drain: streams matrix C (row-major, c_rows x c_cols words at C_OFFSET)
// out of a synchronous-read memory onto a framed valid/ready stream through a
// 2-entry skid FIFO that absorbs the 1-cycle read latency.
// Optional feature: define C_DRAIN_PARITY_EN to add out_parity (even parity of out_data).
// Ports:
//   clk, reset (async, active-low)
//   start, c_rows, c_cols          : launch a drain; sizes sampled with start in IDLE
//   mem_rd_en, mem_addr, mem_rdata : read port, data valid one cycle after mem_rd_en
//   out_data, out_valid, out_ready : element stream
//   out_row_last, out_last         : row / matrix framing of the head element
//   busy, done                     : drain in progress / one-cycle completion pulse
//   out_parity                     : head parity (C_DRAIN_PARITY_EN only)
module c_result_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int C_OFFSET   = 0,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  c_rows,
    input  logic [DIM_WIDTH-1:0]  c_cols,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_row_last,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef C_DRAIN_PARITY_EN
    ,
    output logic                  out_parity
`endif
);
    localparam int TW = 2 * DIM_WIDTH;
    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
    state_t state, state_nxt;
    logic [DIM_WIDTH-1:0]  cols_q, col;
    logic [TW-1:0]         total, rd_idx;
    logic                  inflight, inf_rl, inf_last;
    logic [DATA_WIDTH-1:0] f_data [2];
    logic [1:0]            f_rl, f_last;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic                  pop;
`ifdef C_DRAIN_PARITY_EN
    logic [1:0]            f_par;
    assign out_parity = f_par[rd_ptr];
`endif
    assign pop          = out_valid & out_ready;
    assign out_valid    = count != 2'd0;
    assign out_data     = f_data[rd_ptr];
    assign out_row_last = out_valid & f_rl[rd_ptr];
    assign out_last     = out_valid & f_last[rd_ptr];
    assign busy         = state == READ || state == FLUSH;
    assign done         = state == DONE;
    assign mem_addr     = ADDR_WIDTH'(C_OFFSET) + ADDR_WIDTH'(rd_idx);
    // Occupancy is judged after this cycle's pop, so a stream with out_ready
    // held high keeps one read issued every cycle without bubbles.
    assign mem_rd_en = state == READ && rd_idx < total &&
                       3'(count) + 3'(inflight) - 3'(pop) < 3'd2;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (c_rows == '0 || c_cols == '0) ? DONE : READ;
            READ:    if (rd_idx == total) state_nxt = FLUSH;
            FLUSH:   if (pop && out_last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cols_q    <= '0;
            col       <= '0;
            total     <= '0;
            rd_idx    <= '0;
            inflight  <= 1'b0;
            inf_rl    <= 1'b0;
            inf_last  <= 1'b0;
            f_data[0] <= '0;
            f_data[1] <= '0;
            f_rl      <= '0;
            f_last    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
`ifdef C_DRAIN_PARITY_EN
            f_par     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            inflight <= mem_rd_en;
            if (state == IDLE && start) begin
                cols_q <= c_cols;
                total  <= TW'(c_rows) * TW'(c_cols);
                rd_idx <= '0;
                col    <= '0;
            end
            if (mem_rd_en) begin
                rd_idx   <= rd_idx + 1'b1;
                col      <= (col == cols_q - 1'b1) ? '0 : col + 1'b1;
                inf_rl   <= col == cols_q - 1'b1;
                inf_last <= rd_idx == total - 1'b1;
            end
            if (inflight) begin
                f_data[wr_ptr] <= mem_rdata;
                f_rl[wr_ptr]   <= inf_rl;
                f_last[wr_ptr] <= inf_last;
`ifdef C_DRAIN_PARITY_EN
                f_par[wr_ptr]  <= ^mem_rdata;
`endif
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(inflight) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_c_result_drain.sv
// tb_c_result_drain: self-checking bench for c_result_drain with a behavioural
// memory and an expected-element queue built from the matrix sizes.
module tb_c_result_drain;
    localparam int C_OFF = 0;
    logic        clk, rst_n, start, mem_rd_en, out_valid, out_ready;
    logic        out_row_last, out_last, busy, done;
    logic [7:0]  c_rows, c_cols;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata, out_data;
    logic [31:0] mem [1024];
    int          total, bad;
`ifdef C_DRAIN_PARITY_EN
    logic        out_parity;
`endif
    c_result_drain #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .C_OFFSET(C_OFF), .DIM_WIDTH(8)) dut (
        .clk(clk), .reset(rst_n), .start(start), .c_rows(c_rows), .c_cols(c_cols),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row_last(out_row_last), .out_last(out_last), .busy(busy), .done(done)
`ifdef C_DRAIN_PARITY_EN
        , .out_parity(out_parity)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drains an r x c matrix. mode: 0 ready always, 1 ready 1,0,0 repeating, 2 random.
    // mid: pulse start with other sizes while the drain runs.
    task automatic drain(input int r, input int c, input int mode, input bit mid);
        logic [31:0] eq_d [$];
        bit eq_rl [$];
        bit eq_l [$];
        int tot, issued, xfer;
        bit last_prev, fin, stall;
        logic [31:0] hd;
        tot = r * c;
        for (int i = 0; i < tot; i++) begin
            eq_d.push_back(mem[10'(C_OFF + i)]);
            eq_rl.push_back(i % c == c - 1);
            eq_l.push_back(i == tot - 1);
        end
        start = 1'b1; c_rows = 8'(r); c_cols = 8'(c);
        @(negedge clk);
        start = 1'b0;
        last_prev = (tot == 0); fin = 0; stall = 0; issued = 0; xfer = 0; hd = '0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom % 2);
            if (mid && cyc == 2) begin start = 1'b1; c_rows = 8'd7; c_cols = 8'd7; end
            if (mid && cyc == 3) start = 1'b0;
            #1;
            chk("done", done, last_prev);
            chk("busy", busy, tot > 0 && !last_prev);
            if (last_prev) fin = 1;
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hd);
            end
            if (mem_rd_en) begin
                chk("addr", mem_addr, 10'(C_OFF + issued));
                issued++;
            end
            last_prev = 0;
            if (out_valid && out_ready) begin
                if (eq_d.size() == 0) chk("extra_out", out_valid, 0);
                else begin
                    chk("data", out_data, eq_d[0]);
                    chk("row_last", out_row_last, eq_rl[0]);
                    chk("last", out_last, eq_l[0]);
`ifdef C_DRAIN_PARITY_EN
                    chk("parity", out_parity, ^eq_d[0]);
`endif
                    last_prev = eq_l.pop_front();
                    void'(eq_d.pop_front());
                    void'(eq_rl.pop_front());
                    xfer++;
                end
            end
            chk("outstanding<=2", (issued - xfer) <= 2, 1);
            stall = out_valid && !out_ready;
            hd = out_data;
            @(negedge clk);
        end
        chk("finished", fin, 1);
        chk("xfer_count", xfer, tot);
        chk("read_count", issued, tot);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        bit found;
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; c_rows = '0; c_cols = '0; mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = (i < 16) ? 32'(i + 1) : $urandom;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_data", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        drain(2, 3, 0, 0);
        drain(3, 3, 1, 0);
        drain(0, 5, 0, 0);
        drain(3, 0, 2, 0);
        drain(4, 4, 2, 1);
        start = 1'b1; c_rows = 8'd4; c_cols = 8'd4; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            #1;
            if (out_valid && out_data === mem[3]) found = 1;
            else @(negedge clk);
        end
        chk("rst_found_4th", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_row_last", out_row_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drain(4, 4, 0, 0);
        mem[0] = 32'h0; mem[1] = 32'h1; mem[2] = 32'h3; mem[3] = 32'h7;
        drain(1, 4, 1, 0);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            drain(1 + int'($urandom % 5), 1 + int'($urandom % 5), int'($urandom % 3), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
